// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode constants, frame defaults and the slave FSM state type.
package spi_pkg;

    localparam int         SPI_DATA_W      = 8;
    localparam logic [7:0] SPI_DUMMY_BYTE  = 8'hFF;
    localparam int         SPI_SYNC_STAGES = 2;

    // Mode 0, the only mode the team's master and slave support.
    localparam logic       SPI_CPOL        = 1'b0;
    localparam logic       SPI_CPHA        = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT
    } spi_state_e;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchroniser for one asynchronous input plus a registered toggle flag;
// the consumer decodes rise/fall as toggle combined with the settled level.
module spi_sync
    import spi_pkg::*;
#(
    parameter int   STAGES  = SPI_SYNC_STAGES,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic level_o,
    output logic toggle_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic              toggle_q;

    // NOTE: non-blocking assignments so every flop captures its neighbour's pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= {STAGES{RST_VAL}};
            prev_q   <= RST_VAL;
            toggle_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[STAGES-2:0], d_i};
            prev_q   <= sync_q[STAGES-1];
            toggle_q <= sync_q[STAGES-1] ^ prev_q;
        end
    end

    assign level_o  = sync_q[STAGES-1];
    assign toggle_o = toggle_q;

endmodule

// File: rtl/spi_slave.sv
// Mode-0, MSB-first SPI slave oversampled in the clk domain, with a 1-entry tx holding buffer.
// Define SPI_SLAVE_MISO_HIZ_EN to tri-state SPI_MISO outside a frame and during reset.
module spi_slave
    import spi_pkg::*;
#(
    parameter int                DATA_W      = SPI_DATA_W,
    parameter int                SYNC_STAGES = SPI_SYNC_STAGES,
    parameter logic [DATA_W-1:0] DUMMY_BYTE  = DATA_W'(SPI_DUMMY_BYTE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SPI_SCLK,
    input  logic              SPI_CSN,
    input  logic              SPI_MOSI,
    output logic              SPI_MISO,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              frame_err,
    output logic              tx_underrun
);

    localparam int               CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic sclk_lvl, sclk_tgl, csn_lvl, csn_tgl;
    logic sclk_lead, sclk_trail, sample_edge, shift_edge, csn_rise, csn_fall;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic mosi_s;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(SPI_CPOL)) u_sclk_sync (
        .clk(clk), .rst(rst), .d_i(SPI_SCLK), .level_o(sclk_lvl), .toggle_o(sclk_tgl)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_csn_sync (
        .clk(clk), .rst(rst), .d_i(SPI_CSN), .level_o(csn_lvl), .toggle_o(csn_tgl)
    );

    always_ff @(posedge clk) begin
        if (rst) mosi_sync_q <= '0;
        else     mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], SPI_MOSI};
    end

    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_lead   = sclk_tgl & (sclk_lvl != SPI_CPOL);
    assign sclk_trail  = sclk_tgl & (sclk_lvl == SPI_CPOL);
    assign sample_edge = SPI_CPHA ? sclk_trail : sclk_lead;
    assign shift_edge  = SPI_CPHA ? sclk_lead  : sclk_trail;
    assign csn_rise    = csn_tgl & csn_lvl;
    assign csn_fall    = csn_tgl & ~csn_lvl;

    spi_state_e               state_q;
    logic [CNT_W-1:0]         bit_cnt_q;
    logic [DATA_W-1:0]        tx_shift_q, rx_data_q, buf_data_q, buf_data_d, load_word, rx_next;
    logic [DATA_W-2:0]        rx_shift_q;
    logic                     buf_full_q, buf_full_d, buf_wr, load_now;
    logic                     rx_valid_q, frame_err_q, underrun_q;

    // A byte load happens in LOAD and on the first shift edge after a completed byte.
    assign load_now  = !csn_rise && ((state_q == LOAD) ||
                       (state_q == SHIFT && shift_edge && bit_cnt_q == '0));
    assign buf_wr    = tx_valid && !buf_full_q;
    assign load_word = buf_full_q ? buf_data_q : DUMMY_BYTE;
    assign rx_next   = {rx_shift_q, mosi_s};

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        buf_full_d = buf_full_q;
        buf_data_d = buf_data_q;
        if (load_now) buf_full_d = 1'b0;
        if (buf_wr) begin
            buf_full_d = 1'b1;
            buf_data_d = tx_data;
        end
    end

    // NOTE: the buffer data needs no reset; buf_full_q alone decides whether it is meaningful.
    always_ff @(posedge clk) begin
        if (rst) buf_full_q <= 1'b0;
        else     buf_full_q <= buf_full_d;
        buf_data_q <= buf_data_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            underrun_q  <= 1'b0;
            if (csn_rise) begin
                frame_err_q <= (state_q == SHIFT) && (bit_cnt_q != '0);
                state_q     <= IDLE;
                bit_cnt_q   <= '0;
                tx_shift_q  <= '0;
            end else if (load_now) begin
                tx_shift_q <= load_word;
                underrun_q <= !buf_full_q;
                bit_cnt_q  <= '0;
                state_q    <= SHIFT;
            end else begin
                case (state_q)
                    IDLE: if (csn_fall) state_q <= LOAD;
                    SHIFT: begin
                        if (sample_edge) begin
                            rx_shift_q <= rx_next[DATA_W-2:0];
                            if (bit_cnt_q == LAST_BIT) begin
                                bit_cnt_q  <= '0;
                                rx_data_q  <= rx_next;
                                rx_valid_q <= 1'b1;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            end
                        end else if (shift_edge) begin
                            tx_shift_q <= {tx_shift_q[DATA_W-2:0], 1'b0};
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

`ifdef SPI_SLAVE_MISO_HIZ_EN
    assign SPI_MISO = (rst || csn_lvl) ? 1'bz : tx_shift_q[DATA_W-1];
`else
    assign SPI_MISO = tx_shift_q[DATA_W-1];
`endif

    assign tx_ready    = ~buf_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign busy        = ~csn_lvl;
    assign frame_err   = frame_err_q;
    assign tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a bit-banged mode-0 master plus strobe counters.
module tb_spi_slave;

    localparam int HALF    = 4;
    localparam int SETUP   = 4;
    localparam int TIMEOUT = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       csn = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, busy, frame_err, tx_underrun;

    int n_cmp = 0;
    int n_bad = 0;
    int rx_cnt = 0, err_cnt = 0, udr_cnt = 0;
    int rx_base, err_base, udr_base;
    logic [7:0] rx_log [32];
    logic [7:0] m_tx [4];
    logic [7:0] m_rx [4];

    always #5 clk = ~clk;

    spi_slave dut (
        .clk(clk), .rst(rst),
        .SPI_SCLK(sclk), .SPI_CSN(csn), .SPI_MOSI(mosi), .SPI_MISO(miso),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
        .frame_err(frame_err), .tx_underrun(tx_underrun)
    );

    always @(negedge clk) begin
        if (rx_valid) begin
            if (rx_cnt < 32) rx_log[rx_cnt] = rx_data;
            rx_cnt++;
        end
        if (frame_err)   err_cnt++;
        if (tx_underrun) udr_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic mark();
        rx_base  = rx_cnt;
        err_base = err_cnt;
        udr_base = udr_cnt;
    endtask

    task automatic settle();
        repeat (12) @(negedge clk);
    endtask

    task automatic tx_push(input logic [7:0] d);
        int waited = 0;
        while (!tx_ready && waited < TIMEOUT) begin
            @(negedge clk);
            waited++;
        end
        check("tx_ready_wait", 32'(waited < TIMEOUT), 1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Mode-0 master; the final SCLK fall is driven together with CSN rise.
    task automatic spi_frame(input int nbytes, input int abort_after, input bit rst_end);
        int rises = 0;
        bit done = 1'b0;
        csn = 1'b0;
        repeat (SETUP) @(negedge clk);
        for (int b = 0; b < nbytes && !done; b++) begin
            for (int i = 7; i >= 0 && !done; i--) begin
                mosi = m_tx[b][i];
                repeat (HALF) @(negedge clk);
                sclk = 1'b1;
                m_rx[b][i] = miso;
                rises++;
                repeat (HALF) @(negedge clk);
                sclk = 1'b0;
                if (rises == abort_after || (b == nbytes - 1 && i == 0)) begin
                    csn  = 1'b1;
                    mosi = 1'b0;
                    done = 1'b1;
                    if (rst_end) rst = 1'b1;
                end
            end
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_miso"},      32'(miso),        0);
        check({pfx, "_rx_data"},   32'(rx_data),     0);
        check({pfx, "_rx_valid"},  32'(rx_valid),    0);
        check({pfx, "_tx_ready"},  32'(tx_ready),    1);
        check({pfx, "_busy"},      32'(busy),        0);
        check({pfx, "_frame_err"}, 32'(frame_err),   0);
        check({pfx, "_underrun"},  32'(tx_underrun), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Single byte with preloaded response.
        tx_push(8'hA5);
        check("t1_tx_ready_full", 32'(tx_ready), 0);
        m_tx[0] = 8'h3C;
        mark();
        spi_frame(1, 0, 1'b0);
        settle();
        check("t1_rx_count",  32'(rx_cnt - rx_base), 1);
        check("t1_rx_data",   32'(rx_data), 32'h3C);
        check("t1_master_rx", 32'(m_rx[0]), 32'hA5);
        check("t1_tx_ready",  32'(tx_ready), 1);
        check("t1_underrun",  32'(udr_cnt - udr_base), 0);
        check("t1_frame_err", 32'(err_cnt - err_base), 0);
        check("t1_miso_idle", 32'(miso), 0);
        check("t1_busy_idle", 32'(busy), 0);

        // Empty buffer: dummy byte goes out.
        m_tx[0] = 8'h81;
        mark();
        spi_frame(1, 0, 1'b0);
        settle();
        check("t2_master_rx", 32'(m_rx[0]), 32'hFF);
        check("t2_underrun",  32'(udr_cnt - udr_base), 1);
        check("t2_rx_data",   32'(rx_data), 32'h81);
        check("t2_rx_count",  32'(rx_cnt - rx_base), 1);

        // Three-byte frame, responses supplied through the handshake.
        tx_push(8'h11);
        m_tx[0] = 8'hC1; m_tx[1] = 8'hC2; m_tx[2] = 8'hC3;
        mark();
        fork
            spi_frame(3, 0, 1'b0);
            begin
                tx_push(8'h22);
                tx_push(8'h33);
            end
            begin
                repeat (12) @(negedge clk);
                check("t3_busy", 32'(busy), 1);
            end
        join
        settle();
        check("t3_rx_count", 32'(rx_cnt - rx_base), 3);
        check("t3_rx0",      32'(rx_log[rx_base]),     32'hC1);
        check("t3_rx1",      32'(rx_log[rx_base + 1]), 32'hC2);
        check("t3_rx2",      32'(rx_log[rx_base + 2]), 32'hC3);
        check("t3_mrx0",     32'(m_rx[0]), 32'h11);
        check("t3_mrx1",     32'(m_rx[1]), 32'h22);
        check("t3_mrx2",     32'(m_rx[2]), 32'h33);
        check("t3_underrun", 32'(udr_cnt - udr_base), 0);

        // Abort after 5 SCLK rises.
        m_tx[0] = 8'hE7;
        mark();
        spi_frame(1, 5, 1'b0);
        settle();
        check("t4_frame_err", 32'(err_cnt - err_base), 1);
        check("t4_rx_count",  32'(rx_cnt - rx_base), 0);
        check("t4_rx_hold",   32'(rx_data), 32'hC3);
        check("t4_miso_idle", 32'(miso), 0);
        m_tx[0] = 8'h5A;
        mark();
        spi_frame(1, 0, 1'b0);
        settle();
        check("t4_next_rx",   32'(rx_data), 32'h5A);
        check("t4_next_err",  32'(err_cnt - err_base), 0);

        // Reset pulse at bit 3 with the buffer refilled.
        tx_push(8'h77);
        m_tx[0] = 8'hB2;
        mark();
        fork
            spi_frame(1, 3, 1'b1);
            tx_push(8'h99);
        join
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("t5");
        settle();
        check("t5_no_err",   32'(err_cnt - err_base), 0);
        check("t5_no_rx",    32'(rx_cnt - rx_base), 0);
        check("t5_no_udr",   32'(udr_cnt - udr_base), 0);
        tx_push(8'h42);
        m_tx[0] = 8'hD4;
        spi_frame(1, 0, 1'b0);
        settle();
        check("t5_rx_data",   32'(rx_data), 32'hD4);
        check("t5_master_rx", 32'(m_rx[0]), 32'h42);

        // Write lands on the same edge as LOAD with the buffer empty.
        m_tx[0] = 8'h12; m_tx[1] = 8'h34;
        mark();
        fork
            spi_frame(2, 0, 1'b0);
            begin
                repeat (4) @(negedge clk);
                check("t6_ready_at_load", 32'(tx_ready), 1);
                tx_data  = 8'hB7;
                tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
            end
        join
        settle();
        check("t6_mrx0",     32'(m_rx[0]), 32'hFF);
        check("t6_mrx1",     32'(m_rx[1]), 32'hB7);
        check("t6_underrun", 32'(udr_cnt - udr_base), 1);
        check("t6_rx_count", 32'(rx_cnt - rx_base), 2);
        check("t6_rx0",      32'(rx_log[rx_base]),     32'h12);
        check("t6_rx1",      32'(rx_log[rx_base + 1]), 32'h34);
        check("t6_tx_ready", 32'(tx_ready), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
